mem_reinit_ctrl: RTL and testbench

Sequencer and access arbiter in front of one simple dual-port BRAM wrapper (1-cycle registered read, write-enabled variant of the memory wrapper). On `start` it re-initialises every word with a pattern, then reads every word back and checks it. It reports mismatch count, first failing address and completion. Outside a sequence it passes a single user read/write port straight through to the memory.

---
 rtl/mem_reinit_ctrl_if.sv | 36 +++
 rtl/mem_reinit_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_reinit_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_reinit_ctrl_if.sv
// Memory-side bus between the re-init controller and a simple dual-port BRAM wrapper.
// Latency: read data is valid one cycle after mem_raddr (registered BRAM read).
// Backpressure: none; the memory accepts a write and a read every cycle.
//
// Signals:
//   mem_raddr  read address (32 bits)
//   mem_waddr  write address (32 bits)
//   mem_din    write data
//   mem_we     write enable
//   mem_dout   registered read data
// Modports: master = controller side, slave = memory side.
interface mem_reinit_ctrl_if #(
  parameter int WID_MEM = 36
);
  logic [31:0]        mem_raddr;
  logic [31:0]        mem_waddr;
  logic [WID_MEM-1:0] mem_din;
  logic               mem_we;
  logic [WID_MEM-1:0] mem_dout;

  modport master (
    output mem_raddr,
    output mem_waddr,
    output mem_din,
    output mem_we,
    input  mem_dout
  );

  modport slave (
    input  mem_raddr,
    input  mem_waddr,
    input  mem_din,
    input  mem_we,
    output mem_dout
  );
endinterface

// File: rtl/mem_reinit_ctrl.sv
// Fills a BRAM with a pattern, reads every word back and counts mismatches; passes a user port through when idle.
// Latency: a sequence takes 2*DEPTH_MEM+2 cycles from the accepted start to the done pulse.
// Backpressure: usr_ready=0 while busy or done; user writes and start requests are dropped then, not queued.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, fill_value, pat_mode sequence request and pattern selection (latched on accept)
//   busy, done, error           status: sequence running, one-cycle completion pulse, mismatches seen
//   err_count, first_err_addr   saturating mismatch count, address of the first mismatch
//   usr_ready                   user port owns the memory
//   usr_we/usr_waddr/usr_din    user write port
//   usr_raddr, usr_dout         user read port (usr_dout mirrors mem_dout)
//   mem                         memory bus (master side)
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 36,
  parameter int DEPTH_MEM = 512,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WID_MEM-1:0] fill_value,
  input  logic               pat_mode,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   err_count,
  output logic [31:0]        first_err_addr,
  output logic               usr_ready,
  input  logic               usr_we,
  input  logic [31:0]        usr_waddr,
  input  logic [WID_MEM-1:0] usr_din,
  input  logic [31:0]        usr_raddr,
  output logic [WID_MEM-1:0] usr_dout,
  mem_reinit_ctrl_if.master  mem
);

  localparam int AW = $clog2(DEPTH_MEM);

  typedef logic [AW-1:0]      addr_t;
  typedef logic [WID_MEM-1:0] word_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH_MEM - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    VERIFY,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  addr_t  addr;
  word_t  fill_q;
  logic   mode_q;

  // Read-side pipeline: address issued last cycle, and whether it was a verify read.
  logic   cmp_vld;
  addr_t  cmp_addr;

  // The address is zero-extended or truncated to the word width by the cast.
  function automatic word_t pattern(input word_t seed, input logic mode, input addr_t a);
    return mode ? (seed ^ word_t'(a)) : seed;
  endfunction

  word_t          fill_word;
  word_t          exp_word;
  logic           mismatch;
  logic [CNT_W-1:0] err_count_inc;

  always_comb begin
    fill_word     = pattern(fill_q, mode_q, addr);
    exp_word      = pattern(fill_q, mode_q, cmp_addr);
    mismatch      = cmp_vld && (mem.mem_dout != exp_word);
    err_count_inc = (&err_count) ? err_count : err_count + 1'b1;
  end

  // Memory port mux: the user port drives the memory only in IDLE.
  always_comb begin
    mem.mem_raddr = usr_raddr;
    mem.mem_waddr = usr_waddr;
    mem.mem_din   = usr_din;
    mem.mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        mem.mem_we = usr_we;
      end
      FILL: begin
        mem.mem_waddr = 32'(addr);
        mem.mem_din   = fill_word;
        // Suppress the sequence write in a reset cycle so nothing more lands after reset is seen.
        mem.mem_we    = ~reset;
      end
      VERIFY: begin
        mem.mem_raddr = 32'(addr);
      end
      default: ;
    endcase
  end

  assign usr_dout = mem.mem_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      fill_q         <= '0;
      mode_q         <= 1'b0;
      cmp_vld        <= 1'b0;
      cmp_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      usr_ready      <= 1'b1;
    end else begin
      cmp_vld  <= (state == VERIFY);
      cmp_addr <= addr;

      if (mismatch) begin
        err_count <= err_count_inc;
        error     <= 1'b1;
        if (err_count == '0) begin
          first_err_addr <= 32'(cmp_addr);
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            fill_q         <= fill_value;
            mode_q         <= pat_mode;
            err_count      <= '0;
            error          <= 1'b0;
            first_err_addr <= '0;
            addr           <= '0;
            busy           <= 1'b1;
            usr_ready      <= 1'b0;
            state          <= FILL;
          end
        end
        FILL: begin
          if (addr == LAST_ADDR) begin
            addr  <= '0;
            state <= VERIFY;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        VERIFY: begin
          if (addr == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last read's compare happens this cycle via cmp_vld.
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done      <= 1'b0;
          usr_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Bench for mem_reinit_ctrl: table-driven user-port vectors plus directed fill/verify sequences.
// Two instances: default size, and a small non-power-of-2 one with a narrow word and 4-bit counter.
// Each instance has a behavioural BRAM with registered read and optional read corruption.
module tb_mem_reinit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance 1: default parameters ----------------
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [35:0] fill_value = '0;
  logic        pat_mode = 1'b0;
  logic        busy, done, error, usr_ready;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic        usr_we = 1'b0;
  logic [31:0] usr_waddr = '0;
  logic [35:0] usr_din = '0;
  logic [31:0] usr_raddr = '0;
  logic [35:0] usr_dout;

  mem_reinit_ctrl_if #(.WID_MEM(36)) mif1 ();

  mem_reinit_ctrl dut1 (
    .clk(clk), .reset(reset), .start(start), .fill_value(fill_value), .pat_mode(pat_mode),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .first_err_addr(first_err_addr), .usr_ready(usr_ready), .usr_we(usr_we),
    .usr_waddr(usr_waddr), .usr_din(usr_din), .usr_raddr(usr_raddr), .usr_dout(usr_dout),
    .mem(mif1.master)
  );

  logic [35:0] mem1 [512];
  logic        corrupt1 = 1'b0;
  always @(posedge clk) begin
    if (mif1.mem_we) mem1[mif1.mem_waddr[8:0]] <= mif1.mem_din;
    mif1.mem_dout <= mem1[mif1.mem_raddr[8:0]] ^
      {35'd0, corrupt1 && (mif1.mem_raddr == 32'd5 || mif1.mem_raddr == 32'd300)};
  end

  // ---------------- instance 2: DEPTH 20, 4-bit words, 4-bit counter ----------------
  logic        s2_start = 1'b0;
  logic [3:0]  s2_fill = '0;
  logic        s2_mode = 1'b0;
  logic        s2_busy, s2_done, s2_error, s2_ready;
  logic [3:0]  s2_cnt;
  logic [31:0] s2_first;
  logic [3:0]  s2_dout;

  mem_reinit_ctrl_if #(.WID_MEM(4)) mif2 ();

  mem_reinit_ctrl #(.WID_MEM(4), .DEPTH_MEM(20), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(s2_start), .fill_value(s2_fill), .pat_mode(s2_mode),
    .busy(s2_busy), .done(s2_done), .error(s2_error), .err_count(s2_cnt),
    .first_err_addr(s2_first), .usr_ready(s2_ready), .usr_we(1'b0),
    .usr_waddr(32'd0), .usr_din(4'd0), .usr_raddr(32'd0), .usr_dout(s2_dout),
    .mem(mif2.master)
  );

  logic [3:0] mem2 [32];
  logic       corrupt2 = 1'b0;
  always @(posedge clk) begin
    if (mif2.mem_we) mem2[mif2.mem_waddr[4:0]] <= mif2.mem_din;
    mif2.mem_dout <= mem2[mif2.mem_raddr[4:0]] ^ {3'd0, corrupt2};
  end

  // ---------------- user-port vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [35:0] din;
    logic [31:0] raddr;
    logic        chk_dout;   // read data after the edge is defined
    logic [35:0] exp_dout;
  } vec_t;

  vec_t vecs [7];

  // Starts a sequence on instance 1 from the current cycle (called #1 after an edge).
  // hold: cycle number at which start is finally dropped (0 = drop right after acceptance).
  // uw: hammer user writes to address 7 for the whole sequence.
  task automatic run_seq(input logic [35:0] fv, input logic pm, input int hold, input logic uw,
                         output int done_cyc, output int wr_cnt);
    fill_value = fv;
    pat_mode   = pm;
    start      = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    if (uw) begin
      usr_we    = 1'b1;
      usr_waddr = 32'd7;
      usr_din   = 36'h1_2345_6789;
    end
    chk("busy_rise", busy, 1);
    chk("ready_low_busy", usr_ready, 0);
    chk("cnt_clear_on_start", err_count, 0);
    done_cyc = -1;
    wr_cnt   = 0;
    for (int c = 1; c <= 3000; c++) begin
      if (c == hold) start = 1'b0;
      if (c == 2) fill_value = ~fv;   // latched copy must be used, not the live input
      if (mif1.mem_we) wr_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    usr_we = 1'b0;
  endtask

  int dcyc, wcnt, bad, dcount, bcount;

  initial begin
    vecs[0] = '{1'b1, 32'd7,   36'h1_2345_6789, 32'd7,   1'b0, 36'h0};
    vecs[1] = '{1'b0, 32'd9,   36'hF_0000_0000, 32'd7,   1'b1, 36'h1_2345_6789};
    vecs[2] = '{1'b1, 32'd511, 36'hF_FFFF_FFFF, 32'd7,   1'b1, 36'h1_2345_6789};
    vecs[3] = '{1'b1, 32'd7,   36'h0_0000_0001, 32'd511, 1'b1, 36'hF_FFFF_FFFF};
    vecs[4] = '{1'b0, 32'd0,   36'h0_0000_0000, 32'd7,   1'b1, 36'h0_0000_0001};
    vecs[5] = '{1'b1, 32'd0,   36'hA_AAAA_AAAA, 32'd0,   1'b0, 36'h0};
    vecs[6] = '{1'b0, 32'd3,   36'h5_5555_5555, 32'd0,   1'b1, 36'hA_AAAA_AAAA};

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_ready", usr_ready, 1);
    chk("rst_mem_we", mif1.mem_we, 0);
    chk("rst2_ready", s2_ready, 1);

    // ---- idle user traffic from the table ----
    for (int i = 0; i < 7; i++) begin
      usr_we    = vecs[i].we;
      usr_waddr = vecs[i].waddr;
      usr_din   = vecs[i].din;
      usr_raddr = vecs[i].raddr;
      #2;
      chk($sformatf("tbl%0d_mem_we", i), mif1.mem_we, vecs[i].we);
      chk($sformatf("tbl%0d_mem_waddr", i), mif1.mem_waddr, vecs[i].waddr);
      chk($sformatf("tbl%0d_mem_din", i), mif1.mem_din, vecs[i].din);
      chk($sformatf("tbl%0d_mem_raddr", i), mif1.mem_raddr, vecs[i].raddr);
      chk($sformatf("tbl%0d_ready", i), usr_ready, 1);
      @(posedge clk); #1;
      if (vecs[i].chk_dout) chk($sformatf("tbl%0d_dout", i), usr_dout, vecs[i].exp_dout);
    end
    usr_we    = 1'b0;
    usr_raddr = 32'd0;

    // ---- test 1: constant fill, user writes dropped during the sequence ----
    run_seq(36'h0_0000_00A5, 1'b0, 0, 1'b1, dcyc, wcnt);
    chk("t1_done_cycle", dcyc, 1026);
    chk("t1_write_count", wcnt, 512);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_ready_at_done", usr_ready, 0);
    chk("t1_err_count", err_count, 0);
    chk("t1_error", error, 0);
    bad = 0;
    for (int a = 0; a < 512; a++) if (mem1[a] !== 36'h0_0000_00A5) bad++;
    chk("t1_contents_bad", bad, 0);
    chk("t1_usr_write_dropped", mem1[7], 36'h0_0000_00A5);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", done, 0);
    chk("t1_ready_back", usr_ready, 1);

    // ---- test 2: XOR pattern, start held high while busy ----
    run_seq(36'hF_0000_0000, 1'b1, 600, 1'b0, dcyc, wcnt);
    chk("t2_done_cycle", dcyc, 1026);
    chk("t2_err_count", err_count, 0);
    chk("t2_word_1ff", mem1[511], 36'hF_0000_01FF);
    bad = 0;
    for (int a = 0; a < 512; a++) if (mem1[a] !== (36'hF_0000_0000 ^ 36'(a))) bad++;
    chk("t2_contents_bad", bad, 0);
    @(posedge clk); #1;

    // ---- test 3: two corrupted reads ----
    corrupt1 = 1'b1;
    run_seq(36'h5_A5A5_0F0F, 1'b0, 0, 1'b0, dcyc, wcnt);
    chk("t3_done_cycle", dcyc, 1026);
    chk("t3_err_count", err_count, 2);
    chk("t3_first_err", first_err_addr, 5);
    chk("t3_error", error, 1);
    @(posedge clk); #1;
    chk("t3_error_held_idle", error, 1);
    chk("t3_count_held_idle", err_count, 2);
    chk("t3_ready_idle", usr_ready, 1);

    // ---- back-to-back start in the first IDLE cycle, clean memory ----
    corrupt1 = 1'b0;
    run_seq(36'h0_FFFF_0000, 1'b1, 0, 1'b0, dcyc, wcnt);
    chk("b2b_done_cycle", dcyc, 1026);
    chk("b2b_err_count", err_count, 0);
    chk("b2b_error", error, 0);
    chk("b2b_first", first_err_addr, 0);
    @(posedge clk); #1;

    // ---- test 5: reset in the middle of VERIFY ----
    corrupt1   = 1'b1;
    fill_value = 36'h0;
    pat_mode   = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (699) @(posedge clk);
    #1;
    chk("t5_busy_before", busy, 1);
    chk("t5_count_before", err_count, 1);
    chk("t5_first_before", first_err_addr, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_err_count", err_count, 0);
    chk("t5_error", error, 0);
    chk("t5_first", first_err_addr, 0);
    chk("t5_mem_we", mif1.mem_we, 0);
    chk("t5_ready", usr_ready, 1);
    chk("t5_done", done, 0);
    dcount = 0;
    bcount = 0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (busy) bcount++;
    end
    chk("t5_no_done_pulse", dcount, 0);
    chk("t5_no_busy", bcount, 0);
    corrupt1 = 1'b0;

    // ---- test 6: saturation, truncated XOR pattern, non-power-of-2 depth ----
    corrupt2 = 1'b1;
    s2_fill  = 4'h6;
    s2_mode  = 1'b1;
    s2_start = 1'b1;
    @(posedge clk); #1;
    s2_start = 1'b0;
    chk("t6_busy_rise", s2_busy, 1);
    dcyc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (s2_done) begin
        dcyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t6_done_cycle", dcyc, 42);
    chk("t6_err_sat", s2_cnt, 4'hF);
    chk("t6_first", s2_first, 0);
    chk("t6_error", s2_error, 1);
    chk("t6_word_17", mem2[17], 4'h7);
    bad = 0;
    for (int a = 0; a < 20; a++) if (mem2[a] !== (4'h6 ^ 4'(a))) bad++;
    chk("t6_contents_bad", bad, 0);
    @(posedge clk); #1;
    chk("t6_ready_back", s2_ready, 1);
    corrupt2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
